// File: rtl/aes_mix_columns_seq.sv
// Iterative AES MixColumns: transforms COLS_PER_CYCLE columns of the captured state per CALC cycle.
// A per-block bypass flag passes the state through unchanged for the final round.
module aes_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         bypass_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    localparam int N = 4 / COLS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t       state_q;
    logic [1:0]   cnt_q;
    logic [127:0] work_q;
    logic [127:0] work_d;
    logic [127:0] state_out_q;
    logic         out_valid_q;
    logic         bypass_q;
    logic         last_grp;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // Only the column group selected by cnt_q is rewritten; a bypassed block is never touched.
    always_comb begin
        work_d = work_q;
        for (int c = 0; c < 4; c++) begin
            if (!bypass_q && ((c / COLS_PER_CYCLE) == int'(cnt_q))) begin
                work_d[127-32*c -: 32] = mix_col(work_q[127-32*c -: 32]);
            end
        end
    end

    assign last_grp = (int'(cnt_q) == N - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            state_out_q <= '0;
            out_valid_q <= 1'b0;
            bypass_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q   <= state_in;
                        bypass_q <= bypass_in;
                        cnt_q    <= '0;
                        if (bypass_in) begin
                            state_out_q <= state_in;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    work_q <= work_d;
                    if (last_grp) begin
                        cnt_q       <= '0;
                        state_out_q <= work_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign state_out = state_out_q;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Directed bench for aes_mix_columns_seq: known AES vectors, latency for 1/2/4 columns per cycle,
// bypass, backpressure, mid-block reset and a randomised stream against a GF(2^8) matrix model.
module tb_aes_mix_columns_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] state_in = '0;
    logic         bypass_in = 1'b0;
    logic         out_ready = 1'b1;

    logic         in_ready, out_valid, busy;
    logic [127:0] state_out;
    logic         in_ready2, out_valid2, busy2;
    logic [127:0] state_out2;
    logic         in_ready4, out_valid4, busy4;
    logic [127:0] state_out4;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] KC_IN    = 128'hdb135345f20a225c010101012d26314c;
    localparam logic [127:0] KC_OUT   = 128'h8e4da1bc9fdc589d010101014d7ebdf8;
    localparam logic [127:0] CY_IN    = 128'hc6c6c6c6d4d4d4d5db1353452d26314c;
    localparam logic [127:0] CY_OUT   = 128'hc6c6c6c6d5d5d7d68e4da1bc4d7ebdf8;
    localparam logic [127:0] BY_IN    = 128'h0123456789abcdeffedcba9876543210;

    always #5 clk = ~clk;

    aes_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .bypass_in(bypass_in), .out_valid(out_valid),
        .out_ready(out_ready), .state_out(state_out), .busy(busy));

    aes_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .state_in(state_in), .bypass_in(bypass_in), .out_valid(out_valid2),
        .out_ready(out_ready), .state_out(state_out2), .busy(busy2));

    aes_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .state_in(state_in), .bypass_in(bypass_in), .out_valid(out_valid4),
        .out_ready(out_ready), .state_out(state_out4), .busy(busy4));

    // Reference: generic GF(2^8) multiply by shift-and-add, driven by the circulant {2,3,1,1} matrix.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [1:0] m);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 2; i++) begin
            if (m[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s);
        logic [1:0]   coef [4];
        logic [127:0] r;
        logic [7:0]   acc;
        coef[0] = 2'd2; coef[1] = 2'd3; coef[2] = 2'd1; coef[3] = 2'd1;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(s[127-32*c-8*k -: 8], coef[(k - row + 4) % 4]);
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Starts at a negedge with the main DUT idle and out_ready=1; returns the result and the
    // number of edges after the accept edge before out_valid was seen (99 on timeout).
    task automatic run_block(input logic [127:0] data, input logic byp,
                             output logic [127:0] result, output int lat);
        state_in  = data;
        bypass_in = byp;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = 99;
        result = state_out;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        checks++; if (state_out !== 128'h0) begin errors++; $display("FAIL reset_state_out: got %h exp 0", state_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency_fips;
        out_ready = 1'b1;
        bypass_in = 1'b0;
        state_in  = FIPS_IN;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'(k == 4)) begin errors++; $display("FAIL lat_c1 edge%0d: got %b exp %b", k, out_valid, k == 4); end
            checks++; if (out_valid2 !== 1'(k == 2)) begin errors++; $display("FAIL lat_c2 edge%0d: got %b exp %b", k, out_valid2, k == 2); end
            checks++; if (out_valid4 !== 1'(k == 1)) begin errors++; $display("FAIL lat_c4 edge%0d: got %b exp %b", k, out_valid4, k == 1); end
            if (k == 4) begin
                checks++; if (state_out !== FIPS_OUT) begin errors++; $display("FAIL fips_c1: got %h exp %h", state_out, FIPS_OUT); end
            end
            if (k == 2) begin
                checks++; if (state_out2 !== FIPS_OUT) begin errors++; $display("FAIL fips_c2: got %h exp %h", state_out2, FIPS_OUT); end
            end
            if (k == 1) begin
                checks++; if (state_out4 !== FIPS_OUT) begin errors++; $display("FAIL fips_c4: got %h exp %h", state_out4, FIPS_OUT); end
            end
        end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fips_return_idle: got %b exp 1", in_ready); end
    endtask

    task automatic test_known_columns;
        logic [127:0] res;
        int lat;
        run_block(KC_IN, 1'b0, res, lat);
        checks++; if (res !== KC_OUT) begin errors++; $display("FAIL known_cols: got %h exp %h", res, KC_OUT); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL known_cols_lat: got %0d exp 4", lat); end
        run_block(CY_IN, 1'b0, res, lat);
        checks++; if (res !== CY_OUT) begin errors++; $display("FAIL xtime_carry: got %h exp %h", res, CY_OUT); end
    endtask

    task automatic test_bypass;
        logic [127:0] res;
        int lat;
        run_block(BY_IN, 1'b1, res, lat);
        checks++; if (res !== BY_IN) begin errors++; $display("FAIL bypass_data: got %h exp %h", res, BY_IN); end
        checks++; if (lat !== 0) begin errors++; $display("FAIL bypass_lat: got %0d exp 0", lat); end
        run_block(FIPS_IN, 1'b0, res, lat);
        checks++; if (res !== FIPS_OUT) begin errors++; $display("FAIL after_bypass: got %h exp %h", res, FIPS_OUT); end
    endtask

    task automatic test_backpressure;
        logic [127:0] res;
        int lat;
        int wait_cnt;
        out_ready = 1'b0;
        bypass_in = 1'b0;
        state_in  = KC_IN;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_reach_done: got %b exp 1", out_valid); end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin state_in = FIPS_IN; in_valid = 1'b1; end
            if (i == 4) in_valid = 1'b0;
            @(negedge clk);
            checks++; if (state_out !== KC_OUT) begin errors++; $display("FAIL bp_hold cyc%0d: got %h exp %h", i, state_out, KC_OUT); end
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_flags cyc%0d: got ready=%b valid=%b exp ready=0 valid=1", i, in_ready, out_valid); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid); end
        run_block(FIPS_IN, 1'b0, res, lat);
        checks++; if (res !== FIPS_OUT) begin errors++; $display("FAIL bp_second_block: got %h exp %h", res, FIPS_OUT); end
    endtask

    task automatic test_reset_mid_calc;
        logic [127:0] res;
        int lat;
        out_ready = 1'b1;
        bypass_in = 1'b0;
        state_in  = KC_IN;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b exp 0", out_valid); end
        checks++; if (state_out !== 128'h0) begin errors++; $display("FAIL rst_mid_state_out: got %h exp 0", state_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_after: got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid); end
        run_block(CY_IN, 1'b0, res, lat);
        checks++; if (res !== CY_OUT) begin errors++; $display("FAIL rst_mid_next: got %h exp %h", res, CY_OUT); end
    endtask

    task automatic test_back_to_back;
        logic [127:0] vec [8];
        logic [127:0] exp_q [$];
        logic [127:0] e;
        logic acc, hs;
        int sent, got, cyc, extra;
        for (int i = 0; i < 8; i++) vec[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        sent = 0; got = 0; cyc = 0;
        bypass_in = 1'b0;
        state_in  = vec[0];
        in_valid  = 1'b1;
        while (got < 8 && cyc < 500) begin
            out_ready = 1'($urandom_range(0, 1));
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_dup: got %h exp none", state_out);
                end else begin
                    e = exp_q.pop_front();
                    if (state_out !== e) begin errors++; $display("FAIL stream_out%0d: got %h exp %h", got, state_out, e); end
                end
                got++;
            end
            if (acc) begin
                exp_q.push_back(ref_mix(vec[sent]));
                sent++;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                if (sent < 8) state_in = vec[sent];
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (got !== 8 || sent !== 8 || exp_q.size() !== 0) begin errors++; $display("FAIL stream_count: got out=%0d in=%0d pending=%0d exp 8 8 0", got, sent, exp_q.size()); end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) extra++;
            @(negedge clk);
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL stream_extra: got %0d exp 0", extra); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency_fips();
        test_known_columns();
        test_bypass();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
